// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: sequencer for a Gowin rPLL in dynamic-divider mode.
// Applies one of NUM_MODES divider presets to IDSEL/FBDSEL/ODSEL, pulses the
// PLL reset, qualifies LOCK through a synchroniser, retries on timeout and
// publishes clk_ok once the PLL has held lock long enough.
// Runs on the free-running board oscillator, never on a PLL output.
module pll_dyn_ctrl #(
  parameter int                     NUM_MODES    = 2,
  parameter int                     MODE_W       = 1,
  parameter logic [6*NUM_MODES-1:0] IDSEL_TAB    = '0,
  parameter logic [6*NUM_MODES-1:0] FBDSEL_TAB   = '0,
  parameter logic [6*NUM_MODES-1:0] ODSEL_TAB    = '0,
  parameter int                     DEFAULT_MODE = 0,
  parameter int                     RESET_CYCLES = 16,
  parameter int                     LOCK_STABLE  = 256,
  parameter int                     LOCK_TIMEOUT = 65536,
  parameter int                     MAX_RETRIES  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic              ready,
  output logic              mode_err,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic              pll_reset_p,
  output logic [5:0]        idsel,
  output logic [5:0]        fbdsel,
  output logic [5:0]        odsel,
  output logic [MODE_W-1:0] cur_mode,
  output logic              clk_ok,
  output logic              fail,
  output logic [7:0]        relock_cnt
);

  localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;
  localparam int STB_W  = $clog2(LOCK_STABLE) + 1;
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int RTY_W  = $clog2(MAX_RETRIES) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Pick the 6-bit code of entry idx from a packed preset table.
  function automatic logic [5:0] tab_lookup(input logic [6*NUM_MODES-1:0] tab,
                                            input logic [MODE_W-1:0]      idx);
    logic [5:0] r;
    r = 6'd0;
    for (int k = 0; k < NUM_MODES; k++) begin
      r = (int'(idx) == k) ? tab[6*k +: 6] : r;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic                lock_s;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [STB_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic                pll_reset_q, pll_reset_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [5:0]          idsel_q, idsel_d;
  logic [5:0]          fbdsel_q, fbdsel_d;
  logic [5:0]          odsel_q, odsel_d;
  logic                clk_ok_q, clk_ok_d;
  logic                fail_q, fail_d;
  logic                ready_q, ready_d;
  logic                mode_err_q, mode_err_d;
  logic [7:0]          relock_q, relock_d;
  logic                req_in_range_s;
  logic                accept_s;
  logic                bad_req_s;

  assign lock_s          = sync_q[1];
  assign req_in_range_s  = (int'(mode_req) < NUM_MODES);
  assign accept_s        = ready_q & mode_req_valid & req_in_range_s;
  assign bad_req_s       = ready_q & mode_req_valid & ~req_in_range_s;

  // Two-flop synchroniser bringing the asynchronous PLL LOCK into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  // Next-state and registered-output logic; an accepted request overrides everything.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    stable_cnt_d = stable_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_d      = retry_q;
    pll_reset_d  = pll_reset_q;
    mode_d       = mode_q;
    idsel_d      = idsel_q;
    fbdsel_d     = fbdsel_q;
    odsel_d      = odsel_q;
    clk_ok_d     = clk_ok_q;
    fail_d       = fail_q;
    relock_d     = relock_q;
    mode_err_d   = bad_req_s;

    if (accept_s) begin
      // New preset: codes change on the same edge that PLL reset rises.
      state_d      = ST_HOLD;
      mode_d       = mode_req;
      idsel_d      = tab_lookup(IDSEL_TAB, mode_req);
      fbdsel_d     = tab_lookup(FBDSEL_TAB, mode_req);
      odsel_d      = tab_lookup(ODSEL_TAB, mode_req);
      pll_reset_d  = 1'b1;
      hold_cnt_d   = '0;
      stable_cnt_d = '0;
      tmo_cnt_d    = '0;
      clk_ok_d     = 1'b0;
      fail_d       = 1'b0;
      retry_d      = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          stable_cnt_d = '0;
          tmo_cnt_d    = '0;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d     = ST_WAIT;
            pll_reset_d = 1'b0;
            hold_cnt_d  = '0;
          end else begin
            hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_WAIT: begin
          tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
          stable_cnt_d = lock_s ? (stable_cnt_q + STB_W'(1)) : '0;
          if (lock_s && (stable_cnt_q == STB_LAST)) begin
            // Stable lock wins even when the timeout expires on the same edge.
            state_d      = ST_RUN;
            clk_ok_d     = 1'b1;
            retry_d      = '0;
            stable_cnt_d = '0;
            tmo_cnt_d    = '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            retry_d      = retry_q + RTY_W'(1);
            stable_cnt_d = '0;
            tmo_cnt_d    = '0;
            if ((retry_q + RTY_W'(1)) < RTY_MAX) begin
              state_d     = ST_HOLD;
              pll_reset_d = 1'b1;
              hold_cnt_d  = '0;
            end else begin
              state_d     = ST_FAIL;
              fail_d      = 1'b1;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            // Lock lost: relock on the same preset.
            state_d     = ST_HOLD;
            pll_reset_d = 1'b1;
            hold_cnt_d  = '0;
            clk_ok_d    = 1'b0;
            retry_d     = '0;
            relock_d    = (relock_q == 8'hFF) ? relock_q : (relock_q + 8'd1);
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_d     = ST_FAIL;
          pll_reset_d = 1'b0;
          clk_ok_d    = 1'b0;
          fail_d      = 1'b1;
        end
        default: begin
          state_d     = ST_HOLD;
          pll_reset_d = 1'b1;
          hold_cnt_d  = '0;
        end
      endcase
    end

    ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
  end

  // State and output registers with asynchronous return to the reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      stable_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      retry_q      <= '0;
      pll_reset_q  <= 1'b1;
      mode_q       <= DEF_MODE;
      idsel_q      <= tab_lookup(IDSEL_TAB, DEF_MODE);
      fbdsel_q     <= tab_lookup(FBDSEL_TAB, DEF_MODE);
      odsel_q      <= tab_lookup(ODSEL_TAB, DEF_MODE);
      clk_ok_q     <= 1'b0;
      fail_q       <= 1'b0;
      ready_q      <= 1'b0;
      mode_err_q   <= 1'b0;
      relock_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      retry_q      <= retry_d;
      pll_reset_q  <= pll_reset_d;
      mode_q       <= mode_d;
      idsel_q      <= idsel_d;
      fbdsel_q     <= fbdsel_d;
      odsel_q      <= odsel_d;
      clk_ok_q     <= clk_ok_d;
      fail_q       <= fail_d;
      ready_q      <= ready_d;
      mode_err_q   <= mode_err_d;
      relock_q     <= relock_d;
    end
  end

  assign ready       = ready_q;
  assign mode_err    = mode_err_q;
  assign pll_reset   = pll_reset_q;
  assign pll_reset_p = pll_reset_q;
  assign idsel       = idsel_q;
  assign fbdsel      = fbdsel_q;
  assign odsel       = odsel_q;
  assign cur_mode    = mode_q;
  assign clk_ok      = clk_ok_q;
  assign fail        = fail_q;
  assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: scoreboard bench for pll_dyn_ctrl.
// A timestamp-based reference model predicts every change of the output
// bundle and queues it; a separate monitor pops and compares whenever the
// DUT outputs change.
module tb_pll_dyn_ctrl;

  localparam int NM = 3;
  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int MR = 2;
  localparam logic [17:0] IDT = {6'h23, 6'h12, 6'h01};
  localparam logic [17:0] FBT = {6'h3F, 6'h15, 6'h2A};
  localparam logic [17:0] ODT = {6'h07, 6'h0C, 6'h30};

  localparam int P_HOLD = 0;
  localparam int P_WAIT = 1;
  localparam int P_RUN  = 2;
  localparam int P_FAIL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       pll_lock = 1'b0;
  logic       ready, mode_err, pll_reset, pll_reset_p, clk_ok, fail;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] cur_mode;
  logic [7:0] relock_cnt;

  typedef struct {
    int          n;
    logic [33:0] b;
  } ev_t;
  ev_t sb[$];

  int checks = 0;
  int errors = 0;
  int to_cnt = 0;
  bit done = 1'b0;

  pll_dyn_ctrl #(
    .NUM_MODES(NM), .MODE_W(2), .IDSEL_TAB(IDT), .FBDSEL_TAB(FBT), .ODSEL_TAB(ODT),
    .DEFAULT_MODE(0), .RESET_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT),
    .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .ready(ready), .mode_err(mode_err), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_reset_p(pll_reset_p), .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
    .cur_mode(cur_mode), .clk_ok(clk_ok), .fail(fail), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] entry(input logic [17:0] tab, input int k);
    return tab[6*k +: 6];
  endfunction

  function automatic logic [33:0] mk_b(input logic rst, input int mode, input logic ok,
                                       input logic fl, input logic rdy, input logic merr,
                                       input int rl);
    logic [1:0] m;
    logic [7:0] r;
    m = 2'(mode);
    r = 8'(rl);
    return {rst, rst, entry(IDT, mode), entry(FBT, mode), entry(ODT, mode),
            m, ok, fl, rdy, merr, r};
  endfunction

  function automatic logic [33:0] dut_b();
    return {pll_reset, pll_reset_p, idsel, fbdsel, odsel, cur_mode,
            clk_ok, fail, ready, mode_err, relock_cnt};
  endfunction

  // Reference model: phases with start timestamps, lock history by edge number.
  initial begin : model
    int          n, phase, mark, last_zero, tries, mode, relock;
    logic        rst, ok, fl, merr, ls, rdy_before;
    logic [33:0] b, prev;
    bit          hist[int];
    n = 0; phase = P_HOLD; mark = 0; last_zero = 0; tries = 0; mode = 0; relock = 0;
    rst = 1'b1; ok = 1'b0; fl = 1'b0; merr = 1'b0;
    prev = mk_b(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        n = 0; phase = P_HOLD; mark = 0; last_zero = 0; tries = 0; mode = 0; relock = 0;
        rst = 1'b1; ok = 1'b0; fl = 1'b0; merr = 1'b0;
        hist.delete();
        prev = mk_b(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      end else begin
        n++;
        hist[n] = pll_lock;
        ls = (n >= 3) ? hist[n-2] : 1'b0;
        rdy_before = (phase == P_RUN) || (phase == P_FAIL);
        merr = 1'b0;
        if (rdy_before && mode_req_valid && (int'(mode_req) < NM)) begin
          mode = int'(mode_req); phase = P_HOLD; mark = n; rst = 1'b1;
          ok = 1'b0; fl = 1'b0; tries = 0;
        end else begin
          if (rdy_before && mode_req_valid) merr = 1'b1;
          case (phase)
            P_HOLD: if (n == mark + RC) begin
              phase = P_WAIT; mark = n; last_zero = n; rst = 1'b0;
            end
            P_WAIT: begin
              if (!ls) last_zero = n;
              if (n - last_zero == LS) begin
                phase = P_RUN; ok = 1'b1; tries = 0;
              end else if (n - mark == LT) begin
                tries++;
                if (tries < MR) begin
                  phase = P_HOLD; mark = n; rst = 1'b1;
                end else begin
                  phase = P_FAIL; fl = 1'b1;
                end
              end
            end
            P_RUN: if (!ls) begin
              phase = P_HOLD; mark = n; rst = 1'b1; ok = 1'b0; tries = 0;
              relock = (relock < 255) ? relock + 1 : 255;
            end
            default: ;
          endcase
        end
        b = mk_b(rst, mode, ok, fl, (phase == P_RUN) || (phase == P_FAIL), merr, relock);
        if (b != prev) begin
          sb.push_back('{n: n, b: b});
          prev = b;
        end
      end
    end
  end

  // Monitor: compares reset values, and every DUT output change against the queue.
  initial begin : monitor
    int          mon_n, to_seen;
    logic [33:0] cur, prev, rst_b;
    ev_t         e;
    mon_n = 0; to_seen = 0;
    rst_b = mk_b(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    prev = rst_b;
    forever begin
      @(posedge clk);
      #1;
      cur = dut_b();
      if (to_cnt != to_seen) begin
        checks++; errors++;
        $display("FAIL wait_bound expired count=%0d required=%0d", to_cnt, to_seen);
        to_seen = to_cnt;
      end
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL pending_events left=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (reset) begin
        checks++;
        if (cur !== rst_b) begin
          errors++;
          $display("FAIL reset_values got=%h required=%h", cur, rst_b);
        end
        mon_n = 0;
        prev = rst_b;
      end else begin
        mon_n++;
        if (cur !== prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change edge=%0d got=%h required=%h", mon_n, cur, prev);
          end else begin
            e = sb.pop_front();
            if (e.n != mon_n || e.b !== cur) begin
              errors++;
              $display("FAIL output_event edge=%0d got=%h required edge=%0d value=%h",
                       mon_n, cur, e.n, e.b);
            end
          end
          prev = cur;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int m);
    mode_req = 2'(m);
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
  endtask

  // Wait until the selected output equals val; 0 clk_ok, 1 fail, 2 pll_reset, 3 ready.
  task automatic wait_sig(input int which, input logic val, input int budget);
    int   k;
    logic s;
    k = 0;
    s = 1'b0;
    while (k <= budget) begin
      case (which)
        0:       s = clk_ok;
        1:       s = fail;
        2:       s = pll_reset;
        default: s = ready;
      endcase
      if (s === val) break;
      tick();
      k++;
    end
    if (s !== val) to_cnt++;
  endtask

  // Stimulus: directed scenarios followed by randomized lock/request traffic.
  initial begin : stim
    int pct;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    // Bring-up: lock from cycle 10.
    repeat (9) tick();
    pll_lock = 1'b1;
    wait_sig(0, 1'b1, 100);
    // Switch to mode 2.
    repeat (5) tick();
    req(2);
    wait_sig(0, 1'b1, 100);
    // Permanent lock loss: relock, two timeouts, FAIL; then recover with mode 1.
    repeat (3) tick();
    pll_lock = 1'b0;
    wait_sig(1, 1'b1, 300);
    repeat (3) tick();
    pll_lock = 1'b1;
    req(1);
    wait_sig(0, 1'b1, 100);
    // One-cycle lock glitch in RUN, then a glitch mid-qualification.
    repeat (3) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_sig(2, 1'b1, 20);
    wait_sig(2, 1'b0, 20);
    repeat (7) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_sig(0, 1'b1, 100);
    // Out-of-range request, then a request while busy.
    repeat (3) tick();
    req(3);
    repeat (2) tick();
    req(0);
    req(1);
    wait_sig(0, 1'b1, 100);
    // Reset in the middle of a mode-2 relock.
    req(2);
    wait_sig(2, 1'b0, 20);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wait_sig(0, 1'b1, 100);
    // Randomized traffic with light, heavy and total lock loss.
    for (int seg = 0; seg < 3; seg++) begin
      pct = (seg == 0) ? 2 : ((seg == 1) ? 25 : 100);
      for (int c = 0; c < 600; c++) begin
        pll_lock       = ($urandom_range(0, 99) >= pct);
        mode_req_valid = ($urandom_range(0, 15) == 0);
        mode_req       = 2'($urandom_range(0, 3));
        tick();
      end
      mode_req_valid = 1'b0;
    end
    // Settle into a clean RUN state.
    pll_lock = 1'b1;
    wait_sig(3, 1'b1, 200);
    req(1);
    wait_sig(0, 1'b1, 100);
    repeat (4) tick();
    done = 1'b1;
  end

endmodule
